// File: rtl/hog_pkg.sv
// Shared types and default widths for the HOG block-normalisation stage.
// The saturation helper keeps the divisor clamp consistent for any divisor width.
package hog_pkg;

   typedef enum logic [1:0] {
      ACCUM = 2'd0,
      NORM  = 2'd1,
      EMIT  = 2'd2
   } state_e;

   localparam int BIN_W_DEF      = 9;
   localparam int B_W_DEF        = 9;
   localparam int N_BINS_DEF     = 36;
   localparam int SUM_W_DEF      = 15;
   localparam int NORM_SHIFT_DEF = 5;

   function automatic int sat_max(input int b_w);
      return (1 << (b_w - 1)) - 1;
   endfunction

   localparam int NORM_SAT = sat_max(B_W_DEF);

endpackage

// File: rtl/hog_bin_buffer.sv
// N_BINS x BIN_W register file: synchronous write, combinational read.
// Holds one block while its norm is computed and the bins are streamed out.
module hog_bin_buffer #(
   parameter int BIN_W  = 9,
   parameter int N_BINS = 36,
   parameter int IDX_W  = 6
) (
   input  logic             clk,
   input  logic             we_i,
   input  logic [IDX_W-1:0] waddr_i,
   input  logic [BIN_W-1:0] wdata_i,
   input  logic [IDX_W-1:0] raddr_i,
   output logic [BIN_W-1:0] rdata_o
);

   logic [BIN_W-1:0] mem_q [N_BINS];

   // NOTE: storage has no reset; every entry is rewritten before it is read.
   always_ff @(posedge clk) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/hog_block_norm.sv
// Buffers one HOG block, accumulates its L1 norm and streams each bin with the
// scaled, saturated, never-zero norm as a dividend/divisor pair.
module hog_block_norm
   import hog_pkg::*;
#(
   parameter int BIN_W      = BIN_W_DEF,
   parameter int B_W        = B_W_DEF,
   parameter int N_BINS     = N_BINS_DEF,
   parameter int SUM_W      = SUM_W_DEF,
   parameter int NORM_SHIFT = NORM_SHIFT_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [BIN_W-1:0] in_bin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [BIN_W-1:0] out_a,
   output logic [B_W-1:0]   out_b,
   output logic             out_last
);

   localparam int               IDX_W    = (N_BINS > 1) ? $clog2(N_BINS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_BINS - 1);
   localparam logic [SUM_W:0]   SAT      = (SUM_W + 1)'(sat_max(B_W));

   state_e             state_q, state_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [SUM_W-1:0]   sum_q, sum_d;
   logic [B_W-1:0]     norm_q, norm_d;
   logic               out_valid_q, out_valid_d;
   logic [BIN_W-1:0]   out_a_q, out_a_d;
   logic               out_last_q, out_last_d;

   logic               buf_we;
   logic [IDX_W-1:0]   buf_raddr;
   logic [BIN_W-1:0]   buf_rdata;
   logic [BIN_W-1:0]   mag;
   logic [SUM_W-1:0]   scaled;
   logic [SUM_W:0]     norm_wide;
   logic [B_W-1:0]     norm_sat;
   logic               in_fire;
   logic               out_fire;

   // Gated by rst_n so the very first edge after release can take a bin.
   assign in_ready = rst_n && (state_q == ACCUM);
   assign in_fire  = in_valid && in_ready;
   assign out_fire = out_valid_q && out_ready;

   // Magnitude as unsigned BIN_W bits: -2^(BIN_W-1) maps to 2^(BIN_W-1).
   assign mag       = in_bin[BIN_W-1] ? ((~in_bin) + BIN_W'(1)) : in_bin;
   assign scaled    = sum_q >> NORM_SHIFT;
   assign norm_wide = {1'b0, scaled} + (SUM_W + 1)'(1);
   assign norm_sat  = (norm_wide > SAT) ? SAT[B_W-1:0] : norm_wide[B_W-1:0];

   hog_bin_buffer #(
      .BIN_W  (BIN_W),
      .N_BINS (N_BINS),
      .IDX_W  (IDX_W)
   ) u_buffer (
      .clk     (clk),
      .we_i    (buf_we),
      .waddr_i (idx_q),
      .wdata_i (in_bin),
      .raddr_i (buf_raddr),
      .rdata_o (buf_rdata)
   );

   // NOTE: every output of this block is assigned a default first, so no latches.
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      sum_d       = sum_q;
      norm_d      = norm_q;
      out_valid_d = out_valid_q;
      out_a_d     = out_a_q;
      out_last_d  = out_last_q;
      buf_we      = 1'b0;
      buf_raddr   = '0;

      unique case (state_q)
         ACCUM: begin
            if (in_fire) begin
               buf_we = 1'b1;
               sum_d  = sum_q + SUM_W'(mag);
               if (idx_q == LAST_IDX) begin
                  idx_d   = '0;
                  state_d = NORM;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end
         end
         NORM: begin
            norm_d      = norm_sat;
            sum_d       = '0;
            idx_d       = '0;
            out_valid_d = 1'b1;
            out_a_d     = buf_rdata;
            out_last_d  = (N_BINS == 1);
            state_d     = EMIT;
         end
         EMIT: begin
            // Output registers preload the next bin so they change only on a handshake.
            if (out_fire) begin
               if (out_last_q) begin
                  out_valid_d = 1'b0;
                  out_last_d  = 1'b0;
                  idx_d       = '0;
                  state_d     = ACCUM;
               end else begin
                  buf_raddr  = idx_q + IDX_W'(1);
                  idx_d      = idx_q + IDX_W'(1);
                  out_a_d    = buf_rdata;
                  out_last_d = ((idx_q + IDX_W'(1)) == LAST_IDX);
               end
            end
         end
         default: state_d = ACCUM;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so all update together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ACCUM;
         idx_q       <= '0;
         sum_q       <= '0;
         norm_q      <= '0;
         out_valid_q <= 1'b0;
         out_a_q     <= '0;
         out_last_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         sum_q       <= sum_d;
         norm_q      <= norm_d;
         out_valid_q <= out_valid_d;
         out_a_q     <= out_a_d;
         out_last_q  <= out_last_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_a     = out_a_q;
   assign out_b     = norm_q;
   assign out_last  = out_last_q;

endmodule

// File: tb/tb_hog_block_norm.sv
// Scoreboard bench for hog_block_norm: directed and random blocks against an
// arithmetic reference, random out_ready, and a reset pulse mid-stream.
module tb_hog_block_norm;
   import hog_pkg::*;

   localparam int N  = N_BINS_DEF;
   localparam int BW = BIN_W_DEF;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [BW-1:0] in_bin = '0;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [BW-1:0] out_a;
   logic [8:0]    out_b;
   logic          out_last;

   hog_block_norm dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_bin    (in_bin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_a     (out_a),
      .out_b     (out_b),
      .out_last  (out_last)
   );

   always #5 clk = ~clk;

   typedef struct {
      int a;
      int b;
      bit last;
   } exp_t;

   exp_t sb_q[$];
   int   errors     = 0;
   int   checks     = 0;
   int   total_pops = 0;
   bit   rand_ready = 1'b0;
   bit   rand_gaps  = 1'b0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: L1 norm of the block, shifted, plus one, clamped to the divisor range.
   function automatic int ref_norm(input int blk[N]);
      int s = 0;
      int n;
      foreach (blk[i]) s += (blk[i] < 0) ? -blk[i] : blk[i];
      n = (s >> NORM_SHIFT_DEF) + 1;
      return (n > NORM_SAT) ? NORM_SAT : n;
   endfunction

   task automatic send_block(input int blk[N]);
      int  nb = ref_norm(blk);
      bit  acc;
      int  waited;
      for (int i = 0; i < N; i++) sb_q.push_back('{a: blk[i], b: nb, last: (i == N - 1)});
      for (int i = 0; i < N; i++) begin
         if (rand_gaps && ($urandom_range(0, 3) == 0)) begin
            in_valid = 1'b0;
            in_bin   = BW'($urandom);
            @(posedge clk); #1;
         end
         in_valid = 1'b1;
         in_bin   = BW'(blk[i]);
         waited   = 0;
         forever begin
            acc = in_ready;
            @(posedge clk); #1;
            if (acc) break;
            waited++;
            if (waited > 2000) begin
               check("in_ready_timeout", 0, 1);
               break;
            end
         end
      end
      in_valid = 1'b0;
      check("norm_in_ready", int'(in_ready), 0);
      check("norm_out_valid", int'(out_valid), 0);
      @(posedge clk); #1;
      check("emit_out_valid_rise", int'(out_valid), 1);
   endtask

   initial begin
      forever begin
         @(posedge clk); #1;
         out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // Monitor: compares each accepted pair with the scoreboard and checks stalls hold.
   initial begin
      bit   hv = 1'b0;
      int   ha, hb, hl;
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            hv = 1'b0;
            continue;
         end
         if (hv) begin
            check("hold_valid", int'(out_valid), 1);
            check("hold_a", int'($signed(out_a)), ha);
            check("hold_b", int'(out_b), hb);
            check("hold_last", int'(out_last), hl);
         end
         if (out_valid) begin
            check("emit_in_ready", int'(in_ready), 0);
            check("b_nonzero", int'(out_b != 0), 1);
         end
         if (out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
               check("unexpected_pair", 1, 0);
            end else begin
               e = sb_q.pop_front();
               check("pair_a", int'($signed(out_a)), e.a);
               check("pair_b", int'(out_b), e.b);
               check("pair_last", int'(out_last), int'(e.last));
            end
            total_pops++;
         end
         hv = out_valid && !out_ready;
         ha = int'($signed(out_a));
         hb = int'(out_b);
         hl = int'(out_last);
      end
   end

   initial begin
      int blk[N];
      int base;
      int waited;

      #12;
      check("rst_in_ready", int'(in_ready), 0);
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_out_a", int'(out_a), 0);
      check("rst_out_b", int'(out_b), 0);
      check("rst_out_last", int'(out_last), 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      #1;
      check("release_in_ready", int'(in_ready), 1);

      foreach (blk[i]) blk[i] = 10;
      send_block(blk);
      foreach (blk[i]) blk[i] = 0;
      send_block(blk);
      foreach (blk[i]) blk[i] = -256;
      send_block(blk);
      foreach (blk[i]) blk[i] = (i % 2 == 0) ? 100 : -100;
      send_block(blk);

      rand_ready = 1'b1;
      rand_gaps  = 1'b1;
      for (int k = 0; k < 6; k++) begin
         foreach (blk[i]) blk[i] = (k < 3) ? int'($urandom_range(0, 511)) - 256
                                           : int'($urandom_range(0, 40)) - 20;
         send_block(blk);
      end

      foreach (blk[i]) blk[i] = int'($urandom_range(0, 511)) - 256;
      send_block(blk);
      base = total_pops;
      for (waited = 0; waited < 1000; waited++) begin
         @(posedge clk); #1;
         if (total_pops >= base + 9) break;
      end
      check("reach_pair10", int'(total_pops >= base + 9), 1);
      check("pair10_presented_a", int'($signed(out_a)), blk[9]);
      rst_n = 1'b0;
      #1;
      check("midrst_out_valid", int'(out_valid), 0);
      check("midrst_out_a", int'(out_a), 0);
      check("midrst_out_b", int'(out_b), 0);
      check("midrst_out_last", int'(out_last), 0);
      check("midrst_in_ready", int'(in_ready), 0);
      sb_q.delete();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      #1;
      check("midrst_release_in_ready", int'(in_ready), 1);

      foreach (blk[i]) blk[i] = int'($urandom_range(0, 511)) - 256;
      send_block(blk);

      for (waited = 0; waited < 2000; waited++) begin
         if (sb_q.size() == 0) break;
         @(posedge clk); #1;
      end
      check("drain_empty", sb_q.size(), 0);
      repeat (2) @(posedge clk);
      #1;
      check("idle_out_valid", int'(out_valid), 0);
      check("idle_in_ready", int'(in_ready), 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
